// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master: state encoding, default timing,
// and the constants that the bench slave answers with.
package i2c_pkg;

    // Default number of clk cycles per SCL period (multiple of 4, >= 4).
    localparam int DIVIDE_BY_DEFAULT = 8;

    // Behaviour of the bench slave: the address it acknowledges and the
    // byte it returns on a read.
    localparam logic [6:0] SLAVE_ADDR    = 7'h2A;
    localparam logic [7:0] SLAVE_RD_DATA = 8'hCC;

    typedef enum logic [3:0] {
        IDLE,
        START,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_NACK,
        STOP
    } i2c_state_e;

endpackage

// File: rtl/i2c_clk_gen.sv
// SCL phase generator. While run_i is high a phase counter walks through
// one SCL period (DIVIDE_BY cycles): the first half is SCL low and the
// second half is SCL released. Single-cycle strobes mark the points where
// the master may move SDA (middle of SCL low), samples SDA (middle of SCL
// high), reaches the end of SCL low, and finishes the period.
// Strobes fire in the cycle before the event so that registered outputs
// driven from them take effect exactly at the intended phase.
module i2c_clk_gen
    import i2c_pkg::*;
#(
    parameter int DIVIDE_BY = DIVIDE_BY_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic scl_low_o,
    output logic upd_o,
    output logic smp_o,
    output logic half_o,
    output logic last_o
);

    localparam int PW      = $clog2(DIVIDE_BY);
    localparam int HALF    = DIVIDE_BY / 2;
    localparam int QUARTER = DIVIDE_BY / 4;

    logic [PW-1:0] phase_q;
    logic [PW-1:0] phase_d;

    // Next phase: wraps every SCL period, parked at zero while idle.
    always_comb begin
        phase_d = '0;
        if (run_i && (phase_q != PW'(DIVIDE_BY - 1))) begin
            phase_d = phase_q + 1'b1;
        end
    end

    // Phase register.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign scl_low_o = run_i && (phase_q < PW'(HALF));
    assign upd_o     = run_i && (phase_q == PW'(QUARTER - 1));
    assign smp_o     = run_i && (phase_q == PW'(HALF + QUARTER - 1));
    assign half_o    = run_i && (phase_q == PW'(HALF - 1));
    assign last_o    = run_i && (phase_q == PW'(DIVIDE_BY - 1));

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, 7-bit address + R/W, then one data byte
// written or read (read ends with a master NACK), then STOP.
//
// Request handshake: enable acts as "valid" and ready as "ready". A request
// is accepted on a rising clk edge where enable=1 and ready=1; addr, rw and
// data_in are captured on that same edge and ready falls after it. While
// ready=0 enable and the request inputs are ignored. ready returns to 1 on
// the edge that re-enters IDLE.
//
// Both bus lines are open-drain: the master only ever drives 0 or Z.
module i2c_master
    import i2c_pkg::*;
#(
    parameter int DIVIDE_BY = DIVIDE_BY_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] addr,
    input  logic [7:0] data_in,
    input  logic       enable,
    input  logic       rw,
    output logic [7:0] data_out,
    output logic       ready,
    inout  wire        i2c_sda,
    inout  wire        i2c_scl,
    output i2c_state_e dbg_state_o
);

    localparam int CW      = $clog2(DIVIDE_BY);
    localparam int HALF    = DIVIDE_BY / 2;
    localparam int QUARTER = DIVIDE_BY / 4;

    i2c_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;        // START hold and STOP tail timing
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    sh_q, sh_d;          // shared tx/rx shift register
    logic [6:0]    addr_q, addr_d;
    logic          rw_q, rw_d;
    logic [7:0]    din_q, din_d;
    logic          ack_q, ack_d;        // SDA level sampled in an ACK slot
    logic          sda_low_q, sda_low_d;
    logic          stop_hi_q, stop_hi_d; // STOP: SCL already released
    logic [7:0]    data_out_q, data_out_d;
    logic          ready_q, ready_d;

    logic run;
    logic scl_low;
    logic upd;
    logic smp;
    logic half;
    logic last;
    logic sda_in;

    assign sda_in = i2c_sda;

    // SCL runs for every bit slot and for the low half that opens STOP.
    assign run = (state_q == ADDR)    || (state_q == ADDR_ACK) ||
                 (state_q == WR_DATA) || (state_q == WR_ACK)   ||
                 (state_q == RD_DATA) || (state_q == RD_NACK)  ||
                 ((state_q == STOP) && !stop_hi_q);

    i2c_clk_gen #(
        .DIVIDE_BY(DIVIDE_BY)
    ) u_clk_gen (
        .clk      (clk),
        .rst      (rst),
        .run_i    (run),
        .scl_low_o(scl_low),
        .upd_o    (upd),
        .smp_o    (smp),
        .half_o   (half),
        .last_o   (last)
    );

    assign i2c_sda = sda_low_q ? 1'b0 : 1'bz;
    assign i2c_scl = scl_low   ? 1'b0 : 1'bz;

    assign data_out    = data_out_q;
    assign ready       = ready_q;
    assign dbg_state_o = state_q;

    // Transaction sequencing: next state, bus drive and datapath updates.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        sh_d       = sh_q;
        addr_d     = addr_q;
        rw_d       = rw_q;
        din_d      = din_q;
        ack_d      = ack_q;
        sda_low_d  = sda_low_q;
        stop_hi_d  = stop_hi_q;
        data_out_d = data_out_q;

        unique case (state_q)
            IDLE: begin
                sda_low_d = 1'b0;
                stop_hi_d = 1'b0;
                if (enable && ready_q) begin
                    addr_d    = addr;
                    rw_d      = rw;
                    din_d     = data_in;
                    sh_d      = {addr, rw};
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                    // START condition: SDA falls while SCL is still high.
                    sda_low_d = 1'b1;
                    state_d   = START;
                end
            end

            START: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d   = '0;
                    state_d = ADDR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ADDR, WR_DATA: begin
                if (upd) begin
                    sda_low_d = ~sh_q[7];
                end
                if (last) begin
                    sh_d      = {sh_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = (state_q == ADDR) ? ADDR_ACK : WR_ACK;
                    end
                end
            end

            ADDR_ACK: begin
                if (upd) begin
                    sda_low_d = 1'b0;
                end
                if (smp) begin
                    ack_d = sda_in;
                end
                if (last) begin
                    if (ack_q) begin
                        state_d = STOP;
                    end else if (rw_q) begin
                        state_d = RD_DATA;
                    end else begin
                        sh_d    = din_q;
                        state_d = WR_DATA;
                    end
                end
            end

            WR_ACK: begin
                if (upd) begin
                    sda_low_d = 1'b0;
                end
                if (smp) begin
                    ack_d = sda_in;
                end
                if (last) begin
                    state_d = STOP;
                end
            end

            RD_DATA: begin
                if (upd) begin
                    sda_low_d = 1'b0;
                end
                if (smp) begin
                    sh_d = {sh_q[6:0], sda_in};
                end
                if (last) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        data_out_d = sh_q;
                        state_d    = RD_NACK;
                    end
                end
            end

            RD_NACK: begin
                // Leaving SDA released is the NACK that ends a one-byte read.
                if (upd) begin
                    sda_low_d = 1'b0;
                end
                if (last) begin
                    state_d = STOP;
                end
            end

            STOP: begin
                if (!stop_hi_q) begin
                    if (upd) begin
                        sda_low_d = 1'b1;
                    end
                    if (half) begin
                        stop_hi_d = 1'b1;
                        cnt_d     = '0;
                    end
                end else if (cnt_q == CW'(QUARTER - 1)) begin
                    // STOP condition: SDA rises while SCL is high.
                    sda_low_d = 1'b0;
                    stop_hi_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                sda_low_d = 1'b0;
                stop_hi_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // State and datapath registers; reset drops everything straight to IDLE
    // with both lines released and no STOP on the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            sh_q       <= '0;
            addr_q     <= '0;
            rw_q       <= 1'b0;
            din_q      <= '0;
            ack_q      <= 1'b0;
            sda_low_q  <= 1'b0;
            stop_hi_q  <= 1'b0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sh_q       <= sh_d;
            addr_q     <= addr_d;
            rw_q       <= rw_d;
            din_q      <= din_d;
            ack_q      <= ack_d;
            sda_low_q  <= sda_low_d;
            stop_hi_q  <= stop_hi_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: a behavioural slave on the bus, a bus monitor that
// records every 9-bit frame and checks START/STOP discipline, and a
// transaction-level model that predicts frames, data_out and stored bytes.
module tb_i2c_master;
    import i2c_pkg::*;

    localparam int D     = DIVIDE_BY_DEFAULT;
    localparam int LIMIT = 21 * D + 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [6:0] addr    = '0;
    logic [7:0] data_in = '0;
    logic       enable  = 1'b0;
    logic       rw      = 1'b0;
    logic [7:0] data_out;
    logic       ready;
    i2c_state_e dbg_state;
    wire        i2c_sda;
    wire        i2c_scl;

    pullup (i2c_sda);
    pullup (i2c_scl);

    i2c_master #(.DIVIDE_BY(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .data_in    (data_in),
        .enable     (enable),
        .rw         (rw),
        .data_out   (data_out),
        .ready      (ready),
        .i2c_sda    (i2c_sda),
        .i2c_scl    (i2c_scl),
        .dbg_state_o(dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural slave (i2c_slave_model) ----------------
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_AACK, S_WR, S_WACK, S_RD, S_RACK, S_WAIT} slv_e;
    slv_e       s_st = S_IDLE;
    logic       slv_sda_low = 1'b0;
    logic       s_prev_scl = 1'b1;
    logic       s_prev_sda = 1'b1;
    logic [7:0] s_sh = '0;
    logic [7:0] s_tx = '0;
    logic [3:0] s_bits = '0;
    logic       s_rw = 1'b0;
    logic [7:0] slv_store = '0;

    assign i2c_sda = slv_sda_low ? 1'b0 : 1'bz;

    always @(negedge clk) begin : i2c_slave_model
        if (rst) begin
            s_st        <= S_IDLE;
            slv_sda_low <= 1'b0;
            s_prev_scl  <= 1'b1;
            s_prev_sda  <= 1'b1;
            slv_store   <= '0;
            s_bits      <= '0;
        end else begin
            s_prev_scl <= i2c_scl;
            s_prev_sda <= i2c_sda;
            if (s_prev_scl && i2c_scl && s_prev_sda && !i2c_sda) begin
                s_st        <= S_ADDR;
                s_bits      <= '0;
                slv_sda_low <= 1'b0;
            end else if (s_prev_scl && i2c_scl && !s_prev_sda && i2c_sda) begin
                s_st        <= S_IDLE;
                slv_sda_low <= 1'b0;
            end else if (!s_prev_scl && i2c_scl) begin
                if (s_st == S_ADDR || s_st == S_WR) begin
                    s_sh   <= {s_sh[6:0], i2c_sda};
                    s_bits <= s_bits + 1'b1;
                end
            end else if (s_prev_scl && !i2c_scl) begin
                case (s_st)
                    S_ADDR: if (s_bits == 4'd8) begin
                        if (s_sh[7:1] == SLAVE_ADDR) begin
                            slv_sda_low <= 1'b1;
                            s_rw        <= s_sh[0];
                            s_st        <= S_AACK;
                        end else begin
                            s_st <= S_WAIT;
                        end
                    end
                    S_AACK: begin
                        if (s_rw) begin
                            s_tx        <= SLAVE_RD_DATA;
                            slv_sda_low <= ~SLAVE_RD_DATA[7];
                            s_bits      <= 4'd1;
                            s_st        <= S_RD;
                        end else begin
                            slv_sda_low <= 1'b0;
                            s_bits      <= '0;
                            s_st        <= S_WR;
                        end
                    end
                    S_RD: begin
                        if (s_bits == 4'd8) begin
                            slv_sda_low <= 1'b0;
                            s_st        <= S_RACK;
                        end else begin
                            slv_sda_low <= ~s_tx[3'd7 - s_bits[2:0]];
                            s_bits      <= s_bits + 1'b1;
                        end
                    end
                    S_WR: if (s_bits == 4'd8) begin
                        slv_store   <= s_sh;
                        slv_sda_low <= 1'b1;
                        s_st        <= S_WACK;
                    end
                    S_WACK: begin
                        slv_sda_low <= 1'b0;
                        s_st        <= S_WAIT;
                    end
                    S_RACK:  s_st <= S_WAIT;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- bus monitor / protocol checker ----------------
    logic       m_prev_scl = 1'b1;
    logic       m_prev_sda = 1'b1;
    logic       m_busy = 1'b0;
    logic [7:0] m_sh = '0;
    int         m_bits = 0;
    int         m_starts = 0;
    int         m_stops = 0;
    int         m_viol = 0;
    logic [8:0] mon_q[$];   // {ack level, byte}

    always @(negedge clk) begin
        m_prev_scl <= i2c_scl;
        m_prev_sda <= i2c_sda;
        if (rst) begin
            m_busy <= 1'b0;
            m_bits <= 0;
        end else if (m_prev_scl && i2c_scl && (m_prev_sda != i2c_sda)) begin
            if (!i2c_sda) begin
                if (m_busy) m_viol <= m_viol + 1;
                m_busy   <= 1'b1;
                m_starts <= m_starts + 1;
                m_bits   <= 0;
            end else begin
                if (!m_busy) m_viol <= m_viol + 1;
                m_busy  <= 1'b0;
                m_stops <= m_stops + 1;
            end
        end else if (!m_prev_scl && i2c_scl) begin
            if (!m_busy) begin
                m_viol <= m_viol + 1;
            end else if (m_bits == 8) begin
                mon_q.push_back({i2c_sda, m_sh});
                m_bits <= 0;
            end else begin
                m_sh   <= {m_sh[6:0], i2c_sda};
                m_bits <= m_bits + 1;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [8:0] exp_q[$];
    logic [7:0] exp_dout  = 8'h00;
    logic [7:0] exp_store = 8'h00;

    task automatic model_txn(input logic [6:0] a, input logic r, input logic [7:0] d);
        logic hit;
        hit = (a == SLAVE_ADDR);
        exp_q.delete();
        exp_q.push_back({~hit, a, r});
        if (hit && r) begin
            exp_q.push_back({1'b1, SLAVE_RD_DATA});
            exp_dout = SLAVE_RD_DATA;
        end else if (hit) begin
            exp_q.push_back({1'b0, d});
            exp_store = d;
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] d,
                           input int en_cycles, input bit poke, input bit scramble);
        int  base, st0, sp0, v0, cyc;
        bit  done;
        model_txn(a, r, d);
        base = mon_q.size();
        st0  = m_starts;
        sp0  = m_stops;
        v0   = m_viol;
        @(negedge clk);
        addr = a; rw = r; data_in = d; enable = 1'b1;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < LIMIT + 4) begin
            @(negedge clk);
            cyc++;
            if (cyc == en_cycles) enable = 1'b0;
            if (scramble && cyc == en_cycles + 3) begin
                addr    = 7'($urandom_range(0, 127));
                rw      = 1'($urandom_range(0, 1));
                data_in = 8'($urandom_range(0, 255));
            end
            if (poke && cyc == 40) begin addr = 7'h00; enable = 1'b1; end
            if (poke && cyc == 41) enable = 1'b0;
            if (cyc == 1) check_eq("ready_drop", ready, 1'b0);
            else if (ready) done = 1'b1;
        end
        check_eq("latency_ok", (done && cyc <= LIMIT), 1);
        repeat (3) @(negedge clk);
        check_eq("frame_count", mon_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < mon_q.size()) check_eq($sformatf("frame%0d", i), mon_q[base + i], exp_q[i]);
        end
        check_eq("starts", m_starts - st0, 1);
        check_eq("stops", m_stops - sp0, 1);
        check_eq("protocol", m_viol - v0, 0);
        check_eq("data_out", data_out, exp_dout);
        check_eq("slave_store", slv_store, exp_store);
        check_eq("ready_idle", ready, 1'b1);
        check_eq("bus_idle", {i2c_sda, i2c_scl}, 2'b11);
    endtask

    // ---------------- sequence ----------------
    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sp0;
        int wcyc;
        logic [6:0] ra;

        repeat (4) @(negedge clk);
        check_eq("rst_ready", ready, 1'b0);
        check_eq("rst_data_out", data_out, 8'h00);
        check_eq("rst_lines", {i2c_sda, i2c_scl}, 2'b11);
        check_eq("rst_state", dbg_state, IDLE);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("ready_after_rst", ready, 1'b1);

        // Read of the bench slave, with a busy-time request poked mid-read.
        run_txn(SLAVE_ADDR, 1'b1, 8'h00, 5, 1'b1, 1'b0);
        // Write of 0xAA.
        run_txn(SLAVE_ADDR, 1'b0, 8'hAA, 1, 1'b0, 1'b0);
        // Address nobody answers: data_out must keep 0xCC.
        run_txn(7'h15, 1'b1, 8'h00, 1, 1'b0, 1'b0);

        for (int t = 0; t < 12; t++) begin
            ra = ($urandom_range(0, 1) == 1) ? SLAVE_ADDR : 7'($urandom_range(0, 127));
            run_txn(ra, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                    $urandom_range(1, 4), 1'b0, 1'b1);
        end

        // Reset in the middle of a read data phase.
        sp0 = m_stops;
        @(negedge clk);
        addr = SLAVE_ADDR; rw = 1'b1; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        wcyc = 0;
        while (s_st != S_RD && wcyc < LIMIT) begin
            @(negedge clk);
            wcyc++;
        end
        check_eq("reach_rd_data", (wcyc < LIMIT), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("mid_rst_lines", {i2c_sda, i2c_scl}, 2'b11);
        check_eq("mid_rst_ready", ready, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("mid_rst_ready_hold", ready, 1'b0);
        check_eq("mid_rst_data_out", data_out, 8'h00);
        check_eq("mid_rst_no_stop", m_stops - sp0, 0);
        exp_dout  = 8'h00;
        exp_store = 8'h00;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_rst_ready_back", ready, 1'b1);
        check_eq("mid_rst_data_out_after", data_out, 8'h00);

        // Recovery after reset.
        run_txn(SLAVE_ADDR, 1'b1, 8'h00, 2, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter DIVIDE_BY, default 8, clk cycles per SCL period; legal values are multiples of 4 that are at least 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port addr, input, 7 bits: target slave address.
REQ-005 SHALL have port data_in, input, 8 bits: byte to transmit on a write.
REQ-006 SHALL have port enable, input, 1 bit: transaction request, sampled while ready=1.
REQ-007 SHALL have port rw, input, 1 bit: 1 = read, 0 = write.
REQ-008 SHALL have port data_out, output, 8 bits: last byte read from the slave.
REQ-009 SHALL have port ready, output, 1 bit: idle and able to accept a request.
REQ-010 SHALL have port i2c_sda, inout, 1 bit: open-drain data line (drive 0 or Z).
REQ-011 SHALL have port i2c_scl, inout, 1 bit: open-drain clock line (drive 0 or Z).

Function
REQ-012 SHALL implement FSM states IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_NACK, STOP.
REQ-013 In IDLE, SHALL release SDA and SCL, hold ready=1, and keep data_out unchanged.
REQ-014 On enable=1 in IDLE, SHALL latch addr, rw and data_in, drop ready on the next edge, and enter START.
REQ-015 SHALL ignore enable while ready=0; mid-transaction changes to addr, rw or data_in have no effect.
REQ-016 START SHALL pull SDA low while SCL is released, hold for DIVIDE_BY/2 cycles, then begin SCL toggling.
REQ-017 SCL timing: low for DIVIDE_BY/2 cycles, then released for DIVIDE_BY/2 cycles; no clock-stretching support.
REQ-018 SDA changes only at the midpoint of SCL low; the master samples SDA at the midpoint of SCL high.
REQ-019 ADDR SHALL shift out {addr, rw}, MSB first, over 8 SCL periods.
REQ-020 ADDR_ACK SHALL release SDA for one SCL period and sample it.
- SDA=0 (ACK): go to WR_DATA if rw=0, else RD_DATA.
- SDA=1 (NACK): go to STOP.
REQ-021 WR_DATA SHALL shift out the latched data_in, MSB first; WR_ACK then samples the slave ACK and goes to STOP regardless of its value.
REQ-022 RD_DATA SHALL shift 8 sampled bits, MSB first, into a shift register and copy it to data_out on entering RD_NACK.
REQ-023 RD_NACK SHALL release SDA for one SCL period (master NACK, single-byte read).
REQ-024 STOP SHALL drive SDA low during SCL low, release SCL, then release SDA after DIVIDE_BY/4 cycles, then return to IDLE.
REQ-025 ready SHALL rise on the cycle IDLE is re-entered.
REQ-026 An address NACK SHALL leave data_out unchanged.
REQ-027 A complete read transaction (START through STOP) SHALL finish within 21*DIVIDE_BY+8 cycles of enable.

Reset
REQ-028 While rst=1, SHALL place the FSM in IDLE, release SDA and SCL, set ready=0 and data_out=8'h00, and clear the counters and shift registers.
REQ-029 rst asserted mid-transaction SHALL release both lines on the next clock edge with no STOP generated; ready=1 the first cycle after rst falls.

Structure
REQ-030 Package i2c_pkg SHALL hold:
- the state enum;
- the DIVIDE_BY default;
- the bench slave constants SLAVE_ADDR=7'h2A and SLAVE_RD_DATA=8'hCC.
REQ-031 SHALL contain one sub-module, i2c_clk_gen, a DIVIDE_BY phase counter producing SCL level, SDA-update strobe and sample strobe.
REQ-032 The bench SHALL provide behavioural slave model i2c_slave_model with the following behaviour:
- pull-ups on both lines;
- ACK of address SLAVE_ADDR;
- returns SLAVE_RD_DATA on a read;
- stores the written byte on a write.

Verification
REQ-033 Read: addr=7'h2A, rw=1, enable high for 5 cycles -> byte 0x55 on bus, slave ACK, data_out=8'hCC, master NACK, STOP, ready=1 within 176 cycles.
REQ-034 Write: addr=7'h2A, rw=0, data_in=8'hAA -> bus bytes 0x54 then 0xAA, slave stores 8'hAA, STOP, ready=1.
REQ-035 Wrong address: addr=7'h15, rw=1 -> NACK, STOP right after ADDR_ACK, data_out keeps its prior value (8'hCC).
REQ-036 Busy: enable pulsed with addr=7'h00 mid-read -> ignored; transaction completes with 0x55 address byte.
REQ-037 Reset mid-read during RD_DATA -> SDA and SCL both read 1 the next cycle, ready=0 while rst=1, ready=1 one cycle after release, data_out=8'h00.
REQ-038 A protocol checker SHALL verify throughout that SDA changes only while SCL=0, except at START and STOP.
